// File: rtl/bcd_serial_subtractor_ctrl.sv
// Serial packed-BCD subtractor: one digit per clock through a shared
// single-digit BCD subtractor, with a ten's-complement correction pass
// that turns a negative raw difference into sign-magnitude form.

// Single-digit BCD subtractor: diff = a - b - borrow_in, wrapped into 0..9.
module bcd_subtractor (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       borrow_i,
    output logic [3:0] diff_o,
    output logic       borrow_o
);
    logic [4:0] raw;

    // Five-bit two's-complement difference; bit 4 set means the digit went negative.
    always_comb begin
        raw      = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, borrow_i};
        borrow_o = raw[4];
        diff_o   = raw[4] ? (raw[3:0] + 4'd10) : raw[3:0];
    end
endmodule

module bcd_serial_subtractor_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   result_o,
    output logic                  neg_o,
    output logic                  invalid_o
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             borrow_q,  borrow_d;
    logic [W-1:0]     result_q,  result_d;
    logic             neg_q,     neg_d;
    logic             invalid_q, invalid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    logic [3:0]       dig_a;
    logic [3:0]       dig_b;
    logic [3:0]       dig_diff;
    logic             dig_borrow;

    // True when any nibble of a packed operand is outside 0..9.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // The one and only digit arithmetic unit, shared by both passes.
    bcd_subtractor u_digit (
        .a_i      (dig_a),
        .b_i      (dig_b),
        .borrow_i (borrow_q),
        .diff_o   (dig_diff),
        .borrow_o (dig_borrow)
    );

    // Digit operand select: raw pass uses A/B, correction pass computes 0 - result.
    always_comb begin
        dig_a = 4'd0;
        dig_b = 4'd0;
        if (state_q == SUB) begin
            dig_a = a_q[{idx_q, 2'b00} +: 4];
            dig_b = b_q[{idx_q, 2'b00} +: 4];
        end else if (state_q == FIX) begin
            dig_b = result_q[{idx_q, 2'b00} +: 4];
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        // NOTE: every variable gets a hold value first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        result_d  = result_q;
        neg_d     = neg_q;
        invalid_d = invalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d     = '0;
                    borrow_d  = 1'b0;
                    neg_d     = 1'b0;
                    busy_d    = 1'b1;
                    if (has_bad_digit(a_i) || has_bad_digit(b_i)) begin
                        invalid_d = 1'b1;
                        result_d  = '0;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        invalid_d = 1'b0;
                        state_d   = SUB;
                    end
                end
            end
            SUB: begin
                result_d[{idx_q, 2'b00} +: 4] = dig_diff;
                borrow_d = dig_borrow;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (dig_borrow) begin
                        // Raw result is the ten's complement; rerun as 0 - result.
                        neg_d    = 1'b1;
                        borrow_d = 1'b0;
                        state_d  = FIX;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            FIX: begin
                result_d[{idx_q, 2'b00} +: 4] = dig_diff;
                borrow_d = dig_borrow;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // The last correction borrow is always set and carries no information.
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset overrides everything.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            borrow_q  <= 1'b0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            borrow_q  <= borrow_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Operand capture on an accepted start.
    always_ff @(posedge clk_i) begin
        // NOTE: operand registers carry no reset; they are only read after being loaded by an accepted start.
        if (state_q == IDLE && start_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign neg_o     = neg_q;
    assign invalid_o = invalid_q;
endmodule

// File: tb/tb_bcd_serial_subtractor_ctrl.sv
// Self-checking bench for bcd_serial_subtractor_ctrl: directed cases with
// literal expectations plus randomized operations against a decimal model.
module tb_bcd_serial_subtractor_ctrl;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk_i;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         neg_o;
    logic         invalid_o;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit cmp_en = 0;

    // Behavioural model state
    bit           m_busy = 0;
    bit           m_done = 0;
    bit           m_neg  = 0;
    bit           m_inv  = 0;
    logic [W-1:0] m_res  = '0;
    int           m_left = 0;

    bcd_serial_subtractor_ctrl #(.DIGITS(D)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .neg_o     (neg_o),
        .invalid_o (invalid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit any_bad(input logic [W-1:0] v);
        bit r = 0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1;
        return r;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference model: decides outcome and latency at the accepting edge.
    always @(posedge clk_i) begin
        int av, bv;
        if (rst_i) begin
            m_busy = 0; m_done = 0; m_neg = 0; m_inv = 0; m_res = '0; m_left = 0;
        end else if (!m_busy) begin
            if (start_i) begin
                m_busy = 1;
                m_neg  = 0;
                if (any_bad(a_i) || any_bad(b_i)) begin
                    m_inv = 1; m_res = '0; m_left = 0; m_done = 1;
                end else begin
                    av = bcd_to_int(a_i);
                    bv = bcd_to_int(b_i);
                    m_inv  = 0;
                    m_neg  = (av < bv);
                    m_res  = int_to_bcd(m_neg ? bv - av : av - bv);
                    m_left = m_neg ? 2 * D : D;
                    m_done = 0;
                end
            end
        end else if (m_done) begin
            m_busy = 0;
            m_done = 0;
        end else begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_cnt++;
        if (cmp_en) begin
            check("busy", 32'(busy_o), 32'(m_busy));
            check("done", 32'(done_o), 32'(m_done));
            if (!m_busy || m_done) begin
                check("result", 32'(result_o), 32'(m_res));
                check("neg", 32'(neg_o), 32'(m_neg));
                check("invalid", 32'(invalid_o), 32'(m_inv));
            end else begin
                check("invalid_busy", 32'(invalid_o), 32'(m_inv));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start one operation from IDLE and check it against literal values.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input bit exp_neg,
                          input bit exp_inv, input int exp_lat);
        int n = 0;
        a_i = a; b_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom);
        while (done_o !== 1'b1 && n < 4 * D + 8) begin
            tick();
            n++;
        end
        check("lit_latency", 32'(n), 32'(exp_lat));
        check("lit_result", 32'(result_o), 32'(exp_res));
        check("lit_neg", 32'(neg_o), 32'(exp_neg));
        check("lit_invalid", 32'(invalid_o), 32'(exp_inv));
        tick();
    endtask

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad) r[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    initial begin
        int d0;
        int n;
        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
        tick(); tick(); tick();
        cmp_en = 1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Basic positive and negative operations
        run_op(16'h5271, 16'h1834, 16'h3437, 1'b0, 1'b0, D);
        run_op(16'h1834, 16'h5271, 16'h3437, 1'b1, 1'b0, 2 * D);
        // Borrow chains and equal operands
        run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, D);
        run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 2 * D);
        run_op(16'h0042, 16'h0042, 16'h0000, 1'b0, 1'b0, D);
        // Invalid digit, then a valid op clears the flag
        run_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0);
        run_op(16'h0010, 16'h0003, 16'h0007, 1'b0, 1'b0, D);

        // Starts while busy and in DONE are ignored
        d0 = done_cnt;
        a_i = 16'h5271; b_i = 16'h1834; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        a_i = 16'h9999; b_i = 16'h0001; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < 4 * D + 8) begin tick(); n++; end
        check("busy_start_result", 32'(result_o), 32'h3437);
        a_i = 16'h0042; b_i = 16'h0001; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("done_start_ignored", 32'(busy_o), 32'd0);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        run_op(16'h0042, 16'h0001, 16'h0041, 1'b0, 1'b0, D);

        // Reset in the middle of a negative operation
        d0 = done_cnt;
        a_i = 16'h1834; b_i = 16'h5271; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_result", 32'(result_o), 32'd0);
        check("abort_neg", 32'(neg_o), 32'd0);
        check("abort_invalid", 32'(invalid_o), 32'd0);
        tick(); tick(); tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, D);

        // Randomized operations with idle gaps and ignored starts
        for (int k = 0; k < 150; k++) begin
            a_i = rand_operand($urandom_range(0, 7) == 0);
            b_i = ($urandom_range(0, 9) == 0) ? a_i : rand_operand($urandom_range(0, 7) == 0);
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            n = 0;
            while (m_busy && n < 3 * D + 8) begin
                a_i = W'($urandom);
                b_i = W'($urandom);
                start_i = m_busy && !m_done && ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            start_i = 1'b0;
            if (m_busy) check("rand_timeout", 32'(m_busy), 32'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
